// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
//   state_t  : 4-bit FSM state; codes 13..15 are unused and recover to FETCH
//   OP_*     : instr[31:26] opcodes recognised by the decoder
//   FUNCT_*  : instr[5:0] R-type function codes
//   ALUOP_*  : 2-bit operation class from the FSM to the ALU decoder
//   ALUCTL_* : 3-bit ALU control codes driven to the datapath ALU
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's operation class plus the
// R-type funct field onto the 3-bit ALU control.
//   aluop_i      : operation class (add / sub / from funct / or)
//   funct_i      : instr[5:0]
//   alucontrol_o : ALU control to the datapath
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALUCTL_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALUCTL_ADD;
      ALUOP_SUB: alucontrol_o = ALUCTL_SUB;
      ALUOP_OR:  alucontrol_o = ALUCTL_OR;
      default: begin
        // Unknown funct falls back to add; the R-type writeback still happens.
        case (funct_i)
          FUNCT_ADD: alucontrol_o = ALUCTL_ADD;
          FUNCT_SUB: alucontrol_o = ALUCTL_SUB;
          FUNCT_AND: alucontrol_o = ALUCTL_AND;
          FUNCT_OR:  alucontrol_o = ALUCTL_OR;
          FUNCT_SLT: alucontrol_o = ALUCTL_SLT;
          default:   alucontrol_o = ALUCTL_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for a multicycle MIPS datapath (shared ALU,
// unified memory, regfile). One state per cycle; only the state is stored.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   op, funct, zero     : IR fields and ALU zero flag from the datapath
//   pcen                : PC enable = pcwrite | (branch & zero)
//   iord, memwrite      : memory address select / write enable
//   irwrite             : IR load enable
//   regdst, memtoreg,
//   regwrite            : regfile write-port controls
//   alusrca, alusrcb,
//   extop, pcsrc        : datapath mux selects
//   alucontrol          : 3-bit ALU operation
//   state_o             : current state for debug
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       extop,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic [2:0] aluctl;
  logic       pcwrite, branch;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_IMMWB;
      S_ORIEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;  // writeback/terminal and unused codes
    endcase
  end

  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    extop    = 1'b0;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;  // branch target parked in ALUOut
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        extop   = 1'b1;
        aluop   = ALUOP_OR;
      end
      S_IMMWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    pcen = pcwrite | (branch & zero);
    // Reset is synchronous, so the old state is still live during the reset
    // cycle; gate everything so an abandoned instruction cannot write.
    if (reset) begin
      iord = 1'b0; memwrite = 1'b0; irwrite = 1'b0; regdst = 1'b0;
      memtoreg = 1'b0; regwrite = 1'b0; alusrca = 1'b0; alusrcb = 2'b00;
      extop = 1'b0; pcsrc = 2'b00; pcen = 1'b0;
    end
  end

  alu_decoder u_alu_dec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (aluctl)
  );

  assign alucontrol = reset ? 3'b000 : aluctl;
  assign state_o    = state_q;

endmodule
